// File: rtl/reg_dump.sv
// reg_dump: walks a register file from FIRST_REG to LAST_REG and streams each
// captured value out over a valid/ready handshake.
//
// Parameters:
//   FIRST_REG  lowest register index dumped  (default 0)
//   LAST_REG   highest register index dumped (default 31), FIRST_REG <= LAST_REG <= 31
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      one-cycle dump request, only honoured while idle
//   busy       high whenever the block is not idle
//   done       one-cycle pulse when the dump has finished
//   rd_addr    register-file read address (combinational read port)
//   rd_data    register-file read data for rd_addr, same cycle
//   out_valid  out_data/out_idx/out_last are valid
//   out_ready  consumer accepts the current word
//   out_data   captured register value (or checksum)
//   out_idx    register index of out_data
//   out_last   final word of the dump
//
// Optional feature, macro REG_DUMP_CHKSUM_EN: after the last register word, one
// extra word carrying the XOR of all dumped words (out_idx 0, out_last 1).

module reg_dump #(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_idx,
  output logic        out_last
);

  if (!((FIRST_REG <= LAST_REG) && (LAST_REG <= 31))) begin : g_bad_params
    $error("reg_dump: illegal FIRST_REG/LAST_REG combination");
  end

  localparam logic [4:0] FirstIdx = 5'(FIRST_REG);
  localparam logic [4:0] LastIdx  = 5'(LAST_REG);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StRead = 3'd1;
  localparam logic [2:0] StSend = 3'd2;
  localparam logic [2:0] StDone = 3'd3;
`ifdef REG_DUMP_CHKSUM_EN
  localparam logic [2:0] StChk  = 3'd4;
`endif

  logic [2:0]  state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] data_q, data_d;
  logic [4:0]  oidx_q, oidx_d;
  logic        last_q, last_d;
`ifdef REG_DUMP_CHKSUM_EN
  logic [31:0] chk_q, chk_d;
`endif

  logic at_last;
  assign at_last = (idx_q == LastIdx);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    oidx_d  = oidx_q;
    last_d  = last_q;
`ifdef REG_DUMP_CHKSUM_EN
    chk_d   = chk_q;
`endif

    case (state_q)
      StIdle: begin
        idx_d = FirstIdx;
        if (start) begin
          state_d = StRead;
`ifdef REG_DUMP_CHKSUM_EN
          chk_d   = '0;
`endif
        end
      end

      StRead: begin
        // Snapshot: the word is held in data_q, so later register writes
        // cannot disturb a word that is waiting for the consumer.
        data_d  = rd_data;
        oidx_d  = idx_q;
`ifdef REG_DUMP_CHKSUM_EN
        last_d  = 1'b0;
        chk_d   = chk_q ^ rd_data;
`else
        last_d  = at_last;
`endif
        state_d = StSend;
      end

      StSend: begin
        if (out_ready) begin
          if (at_last) begin
`ifdef REG_DUMP_CHKSUM_EN
            // Reuse the output registers for the checksum word so the
            // outputs stay purely registered.
            data_d  = chk_q;
            oidx_d  = '0;
            last_d  = 1'b1;
            state_d = StChk;
`else
            state_d = StDone;
`endif
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = StRead;
          end
        end
      end

`ifdef REG_DUMP_CHKSUM_EN
      StChk: begin
        if (out_ready) begin
          state_d = StDone;
        end
      end
`endif

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= FirstIdx;
      data_q  <= '0;
      oidx_q  <= '0;
      last_q  <= 1'b0;
`ifdef REG_DUMP_CHKSUM_EN
      chk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      oidx_q  <= oidx_d;
      last_q  <= last_d;
`ifdef REG_DUMP_CHKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
`ifdef REG_DUMP_CHKSUM_EN
    out_valid = (state_q == StSend) || (state_q == StChk);
`else
    out_valid = (state_q == StSend);
`endif
    rd_addr  = (state_q == StRead) ? idx_q : FirstIdx;
    out_data = data_q;
    out_idx  = oidx_q;
    // last_q lingers after the dump; only meaningful alongside a valid word.
    out_last = last_q && out_valid;
  end

endmodule
